mmio_uart_tx: RTL and testbench

//  MMIO responder on the crossbar's MMIO port: a UART transmitter (8N1, LSB first) with a write FIFO.
//  The crossbar supplies a word offset already rebased to the MMIO window, plus write data, wren and byte mask.
//  The crossbar samples o_data one cycle after presenting the address, so reads are registered with 1-cycle latency.

---
 rtl/mmio_uart_tx_pkg.sv | 37 +++
 rtl/mmio_uart_tx_fifo.sv | 56 +++++
 rtl/mmio_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
package mmio_uart_tx_pkg;

   localparam logic [29:0] OFF_TXDATA  = 30'd0;
   localparam logic [29:0] OFF_STATUS  = 30'd1;
   localparam logic [29:0] OFF_BAUDDIV = 30'd2;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_ACTIVE  = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_LVL_LSB = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   function automatic logic [31:0] pack_status(input logic       full,
                                               input logic       empty,
                                               input logic       active,
                                               input logic       ovf,
                                               input logic [7:0] lvl);
      logic [31:0] s;
      s                          = '0;
      s[ST_FULL]                 = full;
      s[ST_EMPTY]                = empty;
      s[ST_ACTIVE]               = active;
      s[ST_OVF]                  = ovf;
      s[ST_LVL_LSB+7:ST_LVL_LSB] = lvl;
      return s;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX byte FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle. DEPTH must be a power of two.
module mmio_uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LW'(DEPTH));
   assign level   = level_q;
   assign rd_data = mem[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by level_q.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter (8N1, LSB first): register decode, registered read
// mux, sticky overflow flag, baud counter, frame FSM and shifter.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int DEFAULT_DIV = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [29:0] i_addr,
   input  logic [31:0] i_data,
   input  logic        i_wren,
   input  logic [3:0]  i_mask,
   output logic [31:0] o_data,
   output logic        o_tx,
   output logic        o_busy
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

   logic            wr_txdata, wr_status, wr_baud;
   logic            push_req, ovf_set, ovf_clr;
   logic            fifo_full, fifo_empty, pop;
   logic [7:0]      fifo_rd;
   logic [LW-1:0]   fifo_level;
   logic            ovf_q;
   logic [15:0]     baud_div_q;
   logic [15:0]     reload;
   tx_state_t       state_q, state_d;
   logic [15:0]     baud_cnt_q, baud_cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      sh_q, sh_d;
   logic            bit_end;
   logic            line;
   logic [31:0]     rd_val;
   logic            unused_bits;

   assign unused_bits = ^{i_data[31:16], i_mask[3:2]};

   assign wr_txdata = i_wren && (i_addr == OFF_TXDATA);
   assign wr_status = i_wren && (i_addr == OFF_STATUS);
   assign wr_baud   = i_wren && (i_addr == OFF_BAUDDIV);
   assign push_req  = wr_txdata && i_mask[0];
   assign ovf_set   = push_req && fifo_full && !pop;
   assign ovf_clr   = wr_status && i_mask[0] && i_data[ST_OVF];

   mmio_uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_req),
      .wr_data (i_data[7:0]),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      rd_val = '0;
      case (i_addr)
         OFF_STATUS:  rd_val = pack_status(fifo_full, fifo_empty, state_q != S_IDLE,
                                           ovf_q, 8'(fifo_level));
         OFF_BAUDDIV: rd_val = {16'd0, baud_div_q};
         default:     rd_val = '0;
      endcase
   end

   // Register file: reads sample pre-edge state; overflow set beats W1C.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data     <= '0;
         ovf_q      <= 1'b0;
         baud_div_q <= 16'(DEFAULT_DIV);
      end else begin
         o_data <= rd_val;
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
         if (wr_baud && i_mask[0]) baud_div_q[7:0]  <= i_data[7:0];
         if (wr_baud && i_mask[1]) baud_div_q[15:8] <= i_data[15:8];
      end
   end

   assign reload  = eff_div(baud_div_q) - 16'd1;
   assign bit_end = (baud_cnt_q == 16'd0);

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_d      = bit_q;
      sh_d       = sh_q;
      pop        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_d    = S_START;
               baud_cnt_d = reload;
               sh_d       = fifo_rd;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d    = S_DATA;
               baud_cnt_d = reload;
               bit_d      = 3'd0;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_cnt_d = reload;
               sh_d       = {1'b0, sh_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_d    = S_START;
                  baud_cnt_d = reload;
                  sh_d       = fifo_rd;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_q      <= '0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_q      <= bit_d;
      end
   end

   always_ff @(posedge clk) begin
      sh_q <= sh_d;
   end

   // Line level is registered from the current state, so it trails the FSM by one cycle.
   always_comb begin
      line = 1'b1;
      case (state_q)
         S_START: line = 1'b0;
         S_DATA:  line = sh_q[0];
         default: line = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) o_tx <= 1'b1;
      else        o_tx <= line;
   end

   assign o_busy = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: directed register checks plus randomized frames
// compared against a waveform model built from the 8N1 framing rules.
module tb_mmio_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [29:0] i_addr;
   logic [31:0] i_data;
   logic        i_wren;
   logic [3:0]  i_mask;
   logic [31:0] o_data;
   logic        o_tx;
   logic        o_busy;

   int passed = 0;
   int fails  = 0;
   int total  = 0;
   bit txq[$];
   bit bsq[$];
   bit expq[$];
   logic [31:0] rdv;

   always #5 clk = ~clk;

   mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(434)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_addr (i_addr),
      .i_data (i_data),
      .i_wren (i_wren),
      .i_mask (i_mask),
      .o_data (o_data),
      .o_tx   (o_tx),
      .o_busy (o_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status(input bit full, input bit empty, input bit act,
                                              input bit ovf, input int lvl);
      return (32'(lvl) << 8) | (32'(ovf) << 3) | (32'(act) << 2) | (32'(empty) << 1) | 32'(full);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      txq.push_back(o_tx);
      bsq.push_back(o_busy);
   endtask

   task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
      i_addr = a; i_data = d; i_mask = m; i_wren = 1'b1;
      cyc();
      i_wren = 1'b0; i_mask = 4'h0; i_addr = 30'd0;
   endtask

   task automatic rd(input logic [29:0] a, output logic [31:0] v);
      i_addr = a;
      cyc();
      v = o_data;
      i_addr = 30'd0;
   endtask

   task automatic add_frame(input logic [7:0] b, input int d);
      repeat (d) expq.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (d) expq.push_back(b[i]);
      repeat (d) expq.push_back(1'b1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (o_busy && k < 2000) begin cyc(); k++; end
      chk(tag, 32'(o_busy), 32'd0);
      cyc(); cyc();
   endtask

   // Push n bytes back to back and compare the captured line against the model.
   task automatic run_round(input string tag, input logic [15:0] div_raw, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input bit rnd);
      int d, t, ndiff, nbusy;
      logic [7:0] b;
      wr(30'd2, {16'd0, div_raw}, 4'hF);
      cyc(); cyc();
      d = (div_raw == 16'd0) ? 1 : int'(div_raw);
      t = n * 10 * d;
      txq.delete(); bsq.delete(); expq.delete();
      expq.push_back(1'b1); expq.push_back(1'b1);
      for (int k = 0; k < n; k++) begin
         b = rnd ? 8'($urandom) : ((k == 0) ? b0 : b1);
         wr(30'd0, {24'd0, b}, 4'b0001);
         add_frame(b, d);
      end
      while (txq.size() < 2 + t + 3) cyc();
      while (expq.size() < txq.size()) expq.push_back(1'b1);
      ndiff = 0;
      for (int i = 0; i < txq.size(); i++) if (txq[i] != expq[i]) ndiff++;
      nbusy = 0;
      for (int i = 0; i < bsq.size(); i++) if (bsq[i]) nbusy++;
      chk({tag, "_wave"}, 32'(ndiff), 32'd0);
      chk({tag, "_busy_len"}, 32'(nbusy), 32'(t + 1));
      chk({tag, "_busy_end"}, 32'(bsq[bsq.size()-1]), 32'd0);
   endtask

   initial begin
      logic [7:0] b;
      rst_n = 1'b0; i_addr = '0; i_data = '0; i_wren = 1'b0; i_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", 32'(o_tx), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_odata", o_data, 32'd0);
      rst_n = 1'b1;

      rd(30'd0, rdv); chk("rd_txdata", rdv, 32'd0);
      rd(30'd1, rdv); chk("rd_status", rdv, exp_status(0, 1, 0, 0, 0));
      rd(30'd2, rdv); chk("rd_baud", rdv, 32'd434);

      run_round("f55", 16'd4, 1, 8'h55, 8'h00, 1'b0);
      wait_idle("f55_idle");
      run_round("b2b", 16'd2, 2, 8'hA0, 8'h0F, 1'b0);
      wait_idle("b2b_idle");
      for (int r = 0; r < 4; r++) begin
         int dsel;
         logic [15:0] dv;
         dsel = $urandom_range(0, 4);
         dv = (dsel == 0) ? 16'd0 : (dsel == 1) ? 16'd1 : (dsel == 2) ? 16'd2 :
              (dsel == 3) ? 16'd3 : 16'd5;
         run_round($sformatf("rnd%0d", r), dv, $urandom_range(1, 5), 8'h00, 8'h00, 1'b1);
         wait_idle($sformatf("rnd%0d_idle", r));
      end

      // FIFO fill and overflow with a slow bit period.
      wr(30'd2, 32'd1000, 4'hF);
      wr(30'd0, 32'h0000_0000, 4'b0001);
      for (int k = 1; k < 9; k++) begin
         b = 8'($urandom);
         wr(30'd0, {24'd0, b}, 4'b0001);
      end
      rd(30'd1, rdv); chk("fill_status", rdv, exp_status(1, 0, 1, 0, 8));
      wr(30'd0, 32'h0000_0077, 4'b0001);
      rd(30'd1, rdv); chk("ovf_status", rdv, exp_status(1, 0, 1, 1, 8));
      rd(30'd1, rdv); chk("ovf_reread", rdv, exp_status(1, 0, 1, 1, 8));
      wr(30'd1, 32'h0000_0008, 4'b0010);
      rd(30'd1, rdv); chk("w1c_masked", rdv, exp_status(1, 0, 1, 1, 8));
      wr(30'd1, 32'h0000_0008, 4'b0001);
      rd(30'd1, rdv); chk("w1c_clear", rdv, exp_status(1, 0, 1, 0, 8));

      // Reset mid-frame while the first (0x00) byte's bit 0 is on the line.
      repeat (1400) cyc();
      chk("mid_data_tx", 32'(o_tx), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tx", 32'(o_tx), 32'd1);
      chk("async_rst_busy", 32'(o_busy), 32'd0);
      cyc(); cyc();
      chk("async_rst_odata", o_data, 32'd0);
      rst_n = 1'b1;
      rd(30'd1, rdv); chk("post_rst_status", rdv, exp_status(0, 1, 0, 0, 0));
      rd(30'd2, rdv); chk("post_rst_baud", rdv, 32'd434);

      // BAUDDIV byte-masked writes and unmapped reads.
      wr(30'd2, 32'h0000_0000, 4'hF);
      wr(30'd2, 32'hFFFF_FF07, 4'b0001);
      rd(30'd2, rdv); chk("baud_mask_lo", rdv, 32'h0000_0007);
      wr(30'd2, 32'h1234_AB99, 4'b0010);
      rd(30'd2, rdv); chk("baud_mask_hi", rdv, 32'h0000_AB07);
      rd(30'd5, rdv); chk("rd_unmapped", rdv, 32'd0);
      wr(30'd5, 32'hFFFF_FFFF, 4'hF);
      rd(30'd2, rdv); chk("unmapped_wr_baud", rdv, 32'h0000_AB07);
      rd(30'd1, rdv); chk("unmapped_wr_status", rdv, exp_status(0, 1, 0, 0, 0));
      run_round("div0", 16'd0, 3, 8'h00, 8'h00, 1'b1);
      wait_idle("div0_idle");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
